// File: rtl/mlp_coef_pkg.sv
// rtl/mlp_coef_pkg.sv - generated per-dataset coefficients and shared types for mlp_seq_classifier
package mlp_coef_pkg;

    localparam int N_IN  = 21;
    localparam int N_HID = 3;
    localparam int N_OUT = 3;
    localparam int WGT_W = 8;
    localparam int ACC_W = 24;

    typedef enum logic [1:0] {IDLE, L0, L1, DONE} state_t;

    // Cardio coefficient set; rows are neurons, columns are inputs
    localparam int W0 [N_HID][N_IN] = '{
        '{ -3,   2,  -5,   4,  -6,   1,  38,  -4,   3,  -7,  -2,   5,  -8,  -1,   2,  -6,  -3, -31,  -4, -20, -15},
        '{  1,  -2,   3,  -1,   2,   0,   2,  -3,   1,   2,  -1,   0,   4,  -2,   1,   3,  -1,   5,   0,  -2,   1},
        '{  2,  -1,   3,   0,   4,   1,  12,   2,  -2,   5,   3,  -3,   4,   1,   0,   2,   3, -80,   1,   5,   7}
    };
    localparam int B0 [N_HID] = '{629, -200, 1440};

    localparam int W1 [N_OUT][N_HID] = '{
        '{-15,  50,  26},
        '{-30,  -7,  12},
        '{ 65,   3, -21}
    };
    localparam int B1 [N_OUT] = '{-5271, -62, 6033};

endpackage

// File: rtl/mlp_mac.sv
// rtl/mlp_mac.sv - shared signed multiply-accumulate with ReLU and saturating clip of the accumulator
module mlp_mac #(
    parameter int X_W   = 13,
    parameter int WGT_W = 8,
    parameter int ACC_W = 24,
    parameter int HID_W = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    en,
    input  logic signed [ACC_W-1:0] load_val,
    input  logic        [X_W-1:0]   x,
    input  logic signed [WGT_W-1:0] w,
    output logic        [ACC_W-2:0] relu_val,
    output logic        [HID_W-1:0] clip_val,
    output logic                    clip_sat
);

    localparam logic [ACC_W-2:0] HID_MAX = (ACC_W-1)'({HID_W{1'b1}});

    logic signed [ACC_W-1:0]     acc;
    logic signed [X_W+WGT_W:0]   prod;

    // x is unsigned, so a zero MSB keeps it non-negative in the signed multiply
    assign prod = $signed({1'b0, x}) * w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_val;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

    assign relu_val = acc[ACC_W-1] ? '0 : acc[ACC_W-2:0];
    assign clip_sat = relu_val > HID_MAX;
    assign clip_val = clip_sat ? '1 : relu_val[HID_W-1:0];

endmodule

// File: rtl/mlp_seq_classifier.sv
// rtl/mlp_seq_classifier.sv - time-multiplexed two-layer integer MLP classifier with argmax output
module mlp_seq_classifier #(
    parameter int N_IN  = mlp_coef_pkg::N_IN,
    parameter int IN_W  = 4,
    parameter int N_HID = mlp_coef_pkg::N_HID,
    parameter int N_OUT = mlp_coef_pkg::N_OUT,
    parameter int WGT_W = mlp_coef_pkg::WGT_W,
    parameter int ACC_W = mlp_coef_pkg::ACC_W,
    parameter int HID_W = 13,
    parameter int CLS_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*IN_W-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CLS_W-1:0]       out_class,
    output logic [ACC_W-2:0]       out_score,
    output logic                   out_sat
);
    import mlp_coef_pkg::*;

    localparam int HIW = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int OIW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int NW  = (HIW > OIW) ? HIW : OIW;
    localparam int CW  = $clog2(N_IN + 1);
    localparam logic [CW-1:0] IN_END  = CW'(N_IN);
    localparam logic [CW-1:0] HID_END = CW'(N_HID);
    localparam logic [NW-1:0] LAST_H  = NW'(N_HID - 1);
    localparam logic [NW-1:0] LAST_O  = NW'(N_OUT - 1);

    state_t                  state, state_nx;
    logic [N_IN*IN_W-1:0]    feat;
    logic [HID_W-1:0]        hid [N_HID];
    logic [CW-1:0]           idx;
    logic [NW-1:0]           nrn;
    logic [HIW-1:0]          nrn_h_nx;
    logic [OIW-1:0]          nrn_o_nx;
    logic                    sat;
    logic [CLS_W-1:0]        best_class;
    logic [ACC_W-2:0]        best_score;

    logic                    wr_cycle, mac_en, mac_load, take;
    logic signed [ACC_W-1:0] load_val;
    logic [HID_W-1:0]        mac_x;
    logic signed [WGT_W-1:0] mac_w;
    logic [ACC_W-2:0]        relu_val;
    logic [HID_W-1:0]        clip_val;
    logic                    clip_sat;

    assign nrn_h_nx  = nrn[HIW-1:0] + 1'b1;
    assign nrn_o_nx  = nrn[OIW-1:0] + 1'b1;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    // Strictly-greater replacement keeps the lowest index on ties
    assign take      = (nrn == '0) || (relu_val > best_score);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        wr_cycle = 1'b0;
        mac_en   = 1'b0;
        mac_load = 1'b0;
        load_val = '0;
        mac_x    = '0;
        mac_w    = '0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = L0;
                    mac_load = 1'b1;
                    load_val = ACC_W'(B0[0]);
                end
            end
            L0: begin
                if (idx == IN_END) begin
                    wr_cycle = 1'b1;
                    mac_load = 1'b1;
                    if (nrn == LAST_H) begin
                        state_nx = L1;
                        load_val = ACC_W'(B1[0]);
                    end else begin
                        load_val = ACC_W'(B0[nrn_h_nx]);
                    end
                end else begin
                    mac_en = 1'b1;
                    mac_x  = HID_W'(feat[idx*IN_W +: IN_W]);
                    mac_w  = WGT_W'(W0[nrn[HIW-1:0]][idx]);
                end
            end
            L1: begin
                if (idx == HID_END) begin
                    wr_cycle = 1'b1;
                    if (nrn == LAST_O) begin
                        state_nx = DONE;
                    end else begin
                        mac_load = 1'b1;
                        load_val = ACC_W'(B1[nrn_o_nx]);
                    end
                end else begin
                    mac_en = 1'b1;
                    mac_x  = hid[idx[HIW-1:0]];
                    mac_w  = WGT_W'(W1[nrn[OIW-1:0]][idx[HIW-1:0]]);
                end
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat       <= '0;
            hid        <= '{default: '0};
            idx        <= '0;
            nrn        <= '0;
            sat        <= 1'b0;
            best_class <= '0;
            best_score <= '0;
            out_class  <= '0;
            out_score  <= '0;
            out_sat    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        feat <= in_data;
                        idx  <= '0;
                        nrn  <= '0;
                        sat  <= 1'b0;
                    end
                end
                L0: begin
                    if (wr_cycle) begin
                        hid[nrn[HIW-1:0]] <= clip_val;
                        sat <= sat | clip_sat;
                        idx <= '0;
                        nrn <= (nrn == LAST_H) ? '0 : nrn + 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                L1: begin
                    if (wr_cycle) begin
                        idx <= '0;
                        nrn <= nrn + 1'b1;
                        if (take) begin
                            best_class <= CLS_W'(nrn);
                            best_score <= relu_val;
                        end
                        // Result registers only move at the end, so they hold between inferences
                        if (nrn == LAST_O) begin
                            out_class <= take ? CLS_W'(nrn) : best_class;
                            out_score <= take ? relu_val : best_score;
                            out_sat   <= sat;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mlp_mac #(
        .X_W   (HID_W),
        .WGT_W (WGT_W),
        .ACC_W (ACC_W),
        .HID_W (HID_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (mac_load),
        .en       (mac_en),
        .load_val (load_val),
        .x        (mac_x),
        .w        (mac_w),
        .relu_val (relu_val),
        .clip_val (clip_val),
        .clip_sat (clip_sat)
    );

endmodule
